// File: rtl/fpga_io_pkg.sv
// Shared types and default parameter values for the FPGA I/O conditioner.
package fpga_io_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } rst_state_e;

  localparam int unsigned DefNumButtons      = 4;
  localparam int unsigned DefResetHoldCycles = 251;
  localparam int unsigned DefDebounceCycles  = 65536;
  localparam bit          DefButtonActiveLow = 1'b0;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchronizer, persistence counter, debounced level and edge pulses.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 65536,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            prev_q, press_q, release_q;

  // The synchronizer keeps sampling while the system is held in reset_out.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i ^ BUTTON_ACTIVE_LOW;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      prev_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      prev_q    <= level_q;
      press_q   <= level_q & ~prev_q;
      release_q <= ~level_q & prev_q;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/fpga_io_conditioner.sv
// PLL-lock reset sequencer plus per-button synchronize/debounce/edge-detect channels.
module fpga_io_conditioner
  import fpga_io_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS       = DefNumButtons,
  parameter int unsigned RESET_HOLD_CYCLES = DefResetHoldCycles,
  parameter int unsigned DEBOUNCE_CYCLES   = DefDebounceCycles,
  parameter bit          BUTTON_ACTIVE_LOW = DefButtonActiveLow
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic                   reset_out,
  output logic                   rst_n_out,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release
);

  localparam int unsigned      HoldW    = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD_CYCLES - 1);

  logic             lock1_q, lock2_q;
  rst_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             reset_out_q;
  logic             btn_clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock1_q <= 1'b0;
      lock2_q <= 1'b0;
    end else begin
      lock1_q <= pll_locked;
      lock2_q <= lock1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        hold_cnt_d = '0;
        if (lock2_q) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!lock2_q) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      RUN: begin
        if (!lock2_q) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        hold_cnt_d = '0;
      end
    endcase
  end

  // reset_out follows the registered state, adding one edge after RUN is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      hold_cnt_q  <= '0;
      reset_out_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      reset_out_q <= (state_q != RUN);
    end
  end

  assign reset_out = reset_out_q;
  assign rst_n_out = ~reset_out_q;
  assign btn_clear = reset | reset_out_q;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
    ) u_debounce (
      .clk_i    (clk),
      .reset_i  (reset),
      .clear_i  (btn_clear),
      .raw_i    (buttons_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule

// File: tb/tb_fpga_io_conditioner.sv
// Self-checking bench: directed scenarios plus random stimulus against a history-based model.
module tb_fpga_io_conditioner;

  localparam int NB   = 4;
  localparam int RHC  = 8;
  localparam int DB   = 4;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          reset, pll_locked;
  logic [NB-1:0] raw_h, raw_l;
  logic          rout_h, rn_h, rout_l, rn_l;
  logic [NB-1:0] lvl_h, prs_h, rel_h, lvl_l, prs_l, rel_l;

  always #5 clk = ~clk;

  fpga_io_conditioner #(
    .NUM_BUTTONS(NB), .RESET_HOLD_CYCLES(RHC), .DEBOUNCE_CYCLES(DB), .BUTTON_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .buttons_raw(raw_h),
    .reset_out(rout_h), .rst_n_out(rn_h), .btn_level(lvl_h), .btn_press(prs_h),
    .btn_release(rel_h)
  );

  fpga_io_conditioner #(
    .NUM_BUTTONS(NB), .RESET_HOLD_CYCLES(RHC), .DEBOUNCE_CYCLES(DB), .BUTTON_ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .buttons_raw(raw_l),
    .reset_out(rout_l), .rst_n_out(rn_l), .btn_level(lvl_l), .btn_press(prs_l),
    .btn_release(rel_l)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Input history per edge; eff_hist holds the logical (pressed = 1) button value.
  int            edge_n = -1;
  bit            rst_hist  [NCYC];
  bit            lock_hist [NCYC];
  bit            rout_hist [NCYC];
  logic [NB-1:0] eff_hist  [2][NCYC];
  logic [NB-1:0] lev_hist  [2][NCYC];
  int            last_evt  [2][NB];

  function automatic bit rst_at(int k);
    if (k < 0) return 1'b1;
    return rst_hist[k];
  endfunction

  function automatic bit lock_at(int k);
    if (k < 0) return 1'b0;
    return lock_hist[k];
  endfunction

  function automatic logic [NB-1:0] lev_at(int d, int k);
    if (k < 0) return '0;
    return lev_hist[d][k];
  endfunction

  // Value a channel sees at edge k: raw sampled two edges earlier, zeroed by a reset in between.
  function automatic bit sync_at(int d, int ch, int k);
    if (rst_at(k - 1) || rst_at(k - 2)) return 1'b0;
    return eff_hist[d][k-2][ch];
  endfunction

  // reset_out is low only with no reset in the last RHC+4 edges and lock seen on RHC+1 of them.
  function automatic bit exp_rout(int n);
    for (int k = n - RHC - 3; k <= n; k++) if (rst_at(k)) return 1'b1;
    for (int k = n - RHC - 3; k <= n - 3; k++) if (!lock_at(k)) return 1'b1;
    return 1'b0;
  endfunction

  logic [NB-1:0] exp_prs [2];
  logic [NB-1:0] exp_rel [2];

  task automatic step();
    bit clr, e, all_diff, lv;
    @(posedge clk);
    edge_n++;
    if (edge_n >= NCYC) begin
      $display("FAIL edge_budget: got %0d expected < %0d", edge_n, NCYC);
      $fatal(1, "edge budget exhausted");
    end
    rst_hist[edge_n]    = reset;
    lock_hist[edge_n]   = pll_locked;
    eff_hist[0][edge_n] = raw_h;
    eff_hist[1][edge_n] = ~raw_l;
    e                   = exp_rout(edge_n);
    rout_hist[edge_n]   = e;
    clr = rst_at(edge_n) || (edge_n == 0) || rout_hist[edge_n-1];
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < NB; ch++) begin
        lv = lev_at(d, edge_n - 1)[ch];
        if (clr) begin
          lv = 1'b0;
          last_evt[d][ch] = edge_n;
        end else if (edge_n - last_evt[d][ch] >= DB) begin
          all_diff = 1'b1;
          for (int k = edge_n - DB + 1; k <= edge_n; k++)
            if (sync_at(d, ch, k) == lv) all_diff = 1'b0;
          if (all_diff) begin
            lv = ~lv;
            last_evt[d][ch] = edge_n;
          end
        end
        lev_hist[d][edge_n][ch] = lv;
        exp_prs[d][ch] = !clr && lev_at(d, edge_n - 1)[ch] && !lev_at(d, edge_n - 2)[ch];
        exp_rel[d][ch] = !clr && !lev_at(d, edge_n - 1)[ch] && lev_at(d, edge_n - 2)[ch];
      end
    end
    #1;
    check_eq("reset_out", 32'(rout_h), 32'(e));
    check_eq("reset_out_al", 32'(rout_l), 32'(e));
    check_eq("rst_n_out", 32'(rn_h), 32'(!e));
    check_eq("rst_n_out_al", 32'(rn_l), 32'(!e));
    check_eq("btn_level", 32'(lvl_h), 32'(lev_hist[0][edge_n]));
    check_eq("btn_level_al", 32'(lvl_l), 32'(lev_hist[1][edge_n]));
    check_eq("btn_press", 32'(prs_h), 32'(exp_prs[0]));
    check_eq("btn_press_al", 32'(prs_l), 32'(exp_prs[1]));
    check_eq("btn_release", 32'(rel_h), 32'(exp_rel[0]));
    check_eq("btn_release_al", 32'(rel_l), 32'(exp_rel[1]));
  endtask

  initial begin
    int idx, lock_drop;
    for (int d = 0; d < 2; d++) for (int ch = 0; ch < NB; ch++) last_evt[d][ch] = -1000;
    reset = 1'b1; pll_locked = 1'b0; raw_h = '0; raw_l = '1;
    repeat (3) step();
    check_eq("reset_state_out", 32'(rout_h), 32'd1);
    check_eq("reset_state_lvl", 32'(lvl_h), 32'd0);

    // Power-up: release lands 9 edges after HOLD entry, which is 2 edges after lock is sampled.
    reset = 1'b0; pll_locked = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (i == 11) check_eq("pwrup_hold", 32'(rout_h), 32'd1);
      if (i == 12) check_eq("pwrup_release", 32'(rout_h), 32'd0);
    end

    // Clean press then release on button 2.
    raw_h[2] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 5) check_eq("press_lvl_early", 32'(lvl_h[2]), 32'd0);
      if (i == 6) check_eq("press_lvl", 32'(lvl_h[2]), 32'd1);
      if (i == 7) check_eq("press_pulse", 32'(prs_h), 32'h4);
      if (i == 8) check_eq("press_once", 32'(prs_h), 32'h0);
      check_eq("press_others", 32'(lvl_h & 4'b1011), 32'd0);
    end
    raw_h[2] = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 7) check_eq("release_pulse", 32'(rel_h), 32'h4);
    end

    // 3-cycle glitch on button 0 must vanish.
    raw_h[0] = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      if (i == 4) raw_h[0] = 1'b0;
      step();
      check_eq("glitch_lvl", 32'(lvl_h[0]), 32'd0);
      check_eq("glitch_pulse", 32'(prs_h[0] | rel_h[0]), 32'd0);
    end

    // Active-low channel 1: pin low means pressed.
    raw_l[1] = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 6) check_eq("al_lvl", 32'(lvl_l[1]), 32'd1);
      if (i == 7) check_eq("al_press", 32'(prs_l[1]), 32'd1);
    end
    raw_l[1] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 7) check_eq("al_release", 32'(rel_l[1]), 32'd1);
    end

    // One-cycle lock loss in RUN.
    pll_locked = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      pll_locked = 1'b1;
      if (i == 3) check_eq("lockloss_still_run", 32'(rout_h), 32'd0);
      if (i == 4) check_eq("lockloss_reset", 32'(rout_h), 32'd1);
      if (i == 12) check_eq("lockloss_hold", 32'(rout_h), 32'd1);
      if (i == 13) check_eq("lockloss_release", 32'(rout_h), 32'd0);
    end

    // Reset while button 3 debounce counter sits at 2.
    raw_h[3] = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    step();
    check_eq("midrst_out", 32'(rout_h), 32'd1);
    check_eq("midrst_lvl", 32'(lvl_h), 32'd0);
    check_eq("midrst_pulse", 32'(prs_h), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 11) check_eq("midrst_hold", 32'(rout_h), 32'd1);
      if (i == 12) check_eq("midrst_release", 32'(rout_h), 32'd0);
      if (i == 15) check_eq("midrst_lvl_early", 32'(lvl_h[3]), 32'd0);
      if (i == 16) check_eq("midrst_lvl_late", 32'(lvl_h[3]), 32'd1);
    end
    raw_h[3] = 1'b0;
    repeat (10) step();

    // Random phase: button toggles of random duration, short lock drops, rare resets.
    lock_drop = 0;
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(7) == 0) begin
        idx = $urandom_range(NB - 1);
        raw_h[idx] = ~raw_h[idx];
      end
      if ($urandom_range(7) == 0) begin
        idx = $urandom_range(NB - 1);
        raw_l[idx] = ~raw_l[idx];
      end
      if (lock_drop > 0) lock_drop--;
      else if ($urandom_range(199) == 0) lock_drop = $urandom_range(3, 1);
      pll_locked = (lock_drop == 0);
      reset = ($urandom_range(399) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
